// File: rtl/onehot_grant_decoder_if.sv
// Index/grant bus between the request encoder and onehot_grant_decoder.
// The "release" handshake is carried as release_req because release is a reserved word.
interface onehot_grant_decoder_if #(
  parameter int N     = 8,
  parameter int IDX_W = 3
) ();
  logic             in_valid;
  logic [IDX_W-1:0] in_idx;
  logic             in_ready;
  logic             release_req;
  logic [N-1:0]     grant;
  logic             grant_valid;
  logic [IDX_W-1:0] grant_idx;
  logic             err;
  logic             timeout;

  modport master (
    output in_valid, in_idx, release_req,
    input  in_ready, grant, grant_valid, grant_idx, err, timeout
  );

  modport slave (
    input  in_valid, in_idx, release_req,
    output in_ready, grant, grant_valid, grant_idx, err, timeout
  );
endinterface

// File: rtl/onehot_grant_decoder.sv
// Binary index -> registered one-hot grant with minimum hold and a one-entry pending buffer.
// Optional auto-release after TIMEOUT cycles when GRANT_TIMEOUT_EN is defined.
module onehot_grant_decoder #(
  parameter int N        = 8,
  parameter int IDX_W    = 3,
  parameter int MIN_HOLD = 2,
  parameter int TIMEOUT  = 16,
  parameter int CNT_W    = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  onehot_grant_decoder_if.slave  bus
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACTIVE = 1'b1;

  if (N < 2 || N > (1 << IDX_W) || MIN_HOLD < 1 || TIMEOUT <= MIN_HOLD ||
      (1 << CNT_W) <= TIMEOUT) begin : g_bad_params
    $error("onehot_grant_decoder: inconsistent parameters");
  end

  logic [0:0]       state, state_n;
  logic [IDX_W-1:0] grant_idx_r, idx_n;
  logic             pend_valid, pend_valid_n;
  logic [IDX_W-1:0] pend_idx, pend_idx_n;
  logic [CNT_W-1:0] hold_cnt, hold_n;
  logic [N-1:0]     grant_r, grant_n;
  logic             err_r;

  logic accept, in_range, take, rel_ok, auto_rel, do_rel;

  assign bus.in_ready = !pend_valid;
  assign accept       = bus.in_valid && !pend_valid;
  assign in_range     = {1'b0, bus.in_idx} < (IDX_W+1)'(N);
  assign take         = accept && in_range;
  assign rel_ok       = (state == ACTIVE) && bus.release_req &&
                        (hold_cnt >= CNT_W'(MIN_HOLD - 1));

`ifdef GRANT_TIMEOUT_EN
  logic timeout_r;
  // An honoured release on the same edge wins, so the timeout pulse is suppressed.
  assign auto_rel    = (state == ACTIVE) && !rel_ok &&
                       (hold_cnt >= CNT_W'(TIMEOUT - 1));
  assign bus.timeout = timeout_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) timeout_r <= 1'b0;
    else        timeout_r <= auto_rel;
  end
`else
  assign auto_rel    = 1'b0;
  assign bus.timeout = 1'b0;
`endif

  assign do_rel = rel_ok || auto_rel;

  always_comb begin
    state_n      = state;
    idx_n        = grant_idx_r;
    pend_valid_n = pend_valid;
    pend_idx_n   = pend_idx;
    hold_n       = hold_cnt;
    case (state)
      IDLE: begin
        if (take) begin
          state_n = ACTIVE;
          idx_n   = bus.in_idx;
          hold_n  = '0;
        end
      end
      ACTIVE: begin
        if (do_rel) begin
          // Pending entry first, then same-edge bypass, otherwise drop to IDLE.
          hold_n = '0;
          if (pend_valid) begin
            idx_n        = pend_idx;
            pend_valid_n = 1'b0;
          end else if (take) begin
            idx_n = bus.in_idx;
          end else begin
            state_n = IDLE;
          end
        end else begin
          if (hold_cnt != '1) hold_n = hold_cnt + 1'b1;
          if (take) begin
            pend_valid_n = 1'b1;
            pend_idx_n   = bus.in_idx;
          end
        end
      end
      default: state_n = IDLE;
    endcase
    grant_n = (state_n == ACTIVE) ? (N'(1) << idx_n) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      grant_idx_r <= '0;
      pend_valid  <= 1'b0;
      pend_idx    <= '0;
      hold_cnt    <= '0;
      grant_r     <= '0;
      err_r       <= 1'b0;
    end else begin
      state       <= state_n;
      grant_idx_r <= idx_n;
      pend_valid  <= pend_valid_n;
      pend_idx    <= pend_idx_n;
      hold_cnt    <= hold_n;
      grant_r     <= grant_n;
      err_r       <= accept && !in_range;
    end
  end

  assign bus.grant       = grant_r;
  assign bus.grant_valid = (state == ACTIVE);
  assign bus.grant_idx   = grant_idx_r;
  assign bus.err         = err_r;

endmodule

// File: tb/tb_onehot_grant_decoder.sv
// Directed-vector bench for onehot_grant_decoder: an N=8 instance and an N=6 instance
// for out-of-range indices. Timeout checks follow GRANT_TIMEOUT_EN.
module tb_onehot_grant_decoder;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  onehot_grant_decoder_if #(.N(8), .IDX_W(3)) bus_a ();
  onehot_grant_decoder_if #(.N(6), .IDX_W(3)) bus_b ();

  onehot_grant_decoder #(.N(8), .IDX_W(3), .MIN_HOLD(2), .TIMEOUT(16), .CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a.slave)
  );
  onehot_grant_decoder #(.N(6), .IDX_W(3), .MIN_HOLD(2), .TIMEOUT(16), .CNT_W(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b.slave)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive_a(input logic v, input logic [2:0] idx, input logic rel);
    bus_a.in_valid = v; bus_a.in_idx = idx; bus_a.release_req = rel;
  endtask

  task automatic drive_b(input logic v, input logic [2:0] idx, input logic rel);
    bus_b.in_valid = v; bus_b.in_idx = idx; bus_b.release_req = rel;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    drive_a(0, 0, 0);
    drive_b(0, 0, 0);
    repeat (2) tick();
    check("rst_grant",  32'(bus_a.grant), 32'h0);
    check("rst_gvalid", 32'(bus_a.grant_valid), 32'h0);
    check("rst_gidx",   32'(bus_a.grant_idx), 32'h0);
    check("rst_err",    32'(bus_a.err), 32'h0);
    check("rst_tmo",    32'(bus_a.timeout), 32'h0);
    rst_n = 1'b1;
    tick();
    check("rst_ready",  32'(bus_a.in_ready), 32'h1);

    // Grant 5, early release ignored, second-cycle release honoured
    drive_a(1, 5, 0); tick();
    check("g5_grant",  32'(bus_a.grant), 32'h20);
    check("g5_valid",  32'(bus_a.grant_valid), 32'h1);
    check("g5_idx",    32'(bus_a.grant_idx), 32'h5);
    drive_a(0, 0, 1); tick();
    check("early_rel", 32'(bus_a.grant), 32'h20);
    drive_a(0, 0, 1); tick();
    check("rel_grant", 32'(bus_a.grant), 32'h0);
    check("rel_valid", 32'(bus_a.grant_valid), 32'h0);
    check("idle_idx",  32'(bus_a.grant_idx), 32'h5);
    tick();
    check("idle_rel",  32'(bus_a.grant), 32'h0);

    // Pending: 2 active, queue 6, release switches without a gap
    drive_a(1, 2, 0); tick();
    check("g2_grant",  32'(bus_a.grant), 32'h04);
    drive_a(1, 6, 0); tick();
    check("pend_ready", 32'(bus_a.in_ready), 32'h0);
    check("pend_hold",  32'(bus_a.grant), 32'h04);
    drive_a(0, 0, 1); tick();
    check("pend_grant", 32'(bus_a.grant), 32'h40);
    check("pend_idx",   32'(bus_a.grant_idx), 32'h6);
    check("pend_ready2", 32'(bus_a.in_ready), 32'h1);
    drive_a(0, 0, 0); tick();
    drive_a(0, 0, 1); tick();
    check("pend_rel",   32'(bus_a.grant), 32'h0);

    // Bypass: 3 active, release plus accept of 1 on the same edge
    drive_a(1, 3, 0); tick();
    check("g3_grant",  32'(bus_a.grant), 32'h08);
    drive_a(0, 0, 0); tick();
    drive_a(1, 1, 1); tick();
    check("byp_grant", 32'(bus_a.grant), 32'h02);
    check("byp_valid", 32'(bus_a.grant_valid), 32'h1);
    check("byp_ready", 32'(bus_a.in_ready), 32'h1);
    drive_a(0, 0, 0); tick();
    drive_a(0, 0, 1); tick();
    check("byp_rel",   32'(bus_a.grant), 32'h0);
    drive_a(0, 0, 0);

    // Out-of-range on N=6 instance
    drive_b(1, 7, 0); tick();
    check("oor_err",   32'(bus_b.err), 32'h1);
    check("oor_grant", 32'(bus_b.grant), 32'h0);
    check("oor_valid", 32'(bus_b.grant_valid), 32'h0);
    drive_b(0, 0, 0); tick();
    check("oor_err_clr", 32'(bus_b.err), 32'h0);
    drive_b(1, 2, 0); tick();
    check("b_g2",      32'(bus_b.grant), 32'h04);
    drive_b(1, 7, 0); tick();
    check("oor_act_err",   32'(bus_b.err), 32'h1);
    check("oor_act_ready", 32'(bus_b.in_ready), 32'h1);
    check("oor_act_grant", 32'(bus_b.grant), 32'h04);
    drive_b(1, 6, 1); tick();
    check("oor_byp_grant", 32'(bus_b.grant), 32'h0);
    check("oor_byp_err",   32'(bus_b.err), 32'h1);
    drive_b(1, 5, 0); tick();
    check("b_g5",      32'(bus_b.grant), 32'h20);
    check("b_g5_err",  32'(bus_b.err), 32'h0);
    drive_b(0, 0, 0);

    // Timeout behaviour on grant 4
    drive_a(1, 4, 0); tick();
    drive_a(0, 0, 0);
`ifdef GRANT_TIMEOUT_EN
    for (int i = 0; i < 16; i++) begin
      check("to_hold", 32'(bus_a.grant), 32'h10);
      check("to_quiet", 32'(bus_a.timeout), 32'h0);
      tick();
    end
    check("to_grant", 32'(bus_a.grant), 32'h0);
    check("to_pulse", 32'(bus_a.timeout), 32'h1);
    tick();
    check("to_clr",   32'(bus_a.timeout), 32'h0);
`else
    for (int i = 0; i < 20; i++) begin
      check("hold_grant", 32'(bus_a.grant), 32'h10);
      check("hold_tmo",   32'(bus_a.timeout), 32'h0);
      tick();
    end
    drive_a(0, 0, 1); tick();
    check("hold_rel", 32'(bus_a.grant), 32'h0);
    drive_a(0, 0, 0);
`endif

    // Asynchronous reset mid-grant with a pending entry
    drive_a(1, 4, 0); tick();
    drive_a(1, 7, 0); tick();
    check("mid_pend",  32'(bus_a.in_ready), 32'h0);
    drive_a(0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    check("mid_grant", 32'(bus_a.grant), 32'h0);
    check("mid_valid", 32'(bus_a.grant_valid), 32'h0);
    check("mid_ready", 32'(bus_a.in_ready), 32'h1);
    check("mid_idx",   32'(bus_a.grant_idx), 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst",  32'(bus_a.grant), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
